// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared types and helpers for the sequential restoring divider.
//   div_state_e     : controller states (IDLE, CALC, DONE)
//   cnt_width()     : iteration counter width, clog2(OPER1_LENGTH+1)
//   DivZeroQuotBit  : fill bit for the divide-by-zero quotient (all ones)
// -----------------------------------------------------------------------------
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // Quotient reported on divide by zero is this bit replicated across the width.
   localparam bit DivZeroQuotBit = 1'b1;

   // Counter must hold the value OPER1_LENGTH itself.
   function automatic int unsigned cnt_width(input int unsigned oper1_len);
      return $clog2(oper1_len + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// Ports:
//   i_prem    [OPER2_LENGTH:0]    current partial remainder (always < divisor)
//   i_msb                         next dividend bit shifted in
//   i_divisor [OPER2_LENGTH-1:0]  divisor magnitude
//   o_prem    [OPER2_LENGTH:0]    next partial remainder
//   o_qbit                        quotient bit produced by this iteration
// -----------------------------------------------------------------------------
module div_step
   import divider_pkg::*;
#(
   parameter int unsigned OPER2_LENGTH = 8
) (
   input  logic [OPER2_LENGTH:0]   i_prem,
   input  logic                    i_msb,
   input  logic [OPER2_LENGTH-1:0] i_divisor,
   output logic [OPER2_LENGTH:0]   o_prem,
   output logic                    o_qbit
);

   // One extra bit so the trial difference carries a usable sign bit:
   // shifted value < 2*divisor, so the difference lies in [-divisor, divisor).
   logic [OPER2_LENGTH+1:0] w_shift;
   logic [OPER2_LENGTH+1:0] w_trial;

   assign w_shift = {i_prem, i_msb};
   assign w_trial = w_shift - {2'b00, i_divisor};
   assign o_qbit  = ~w_trial[OPER2_LENGTH+1];
   assign o_prem  = o_qbit ? w_trial[OPER2_LENGTH:0] : w_shift[OPER2_LENGTH:0];

endmodule

// File: rtl/seq_divider.sv
// -----------------------------------------------------------------------------
// seq_divider
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Optional macro SIGNED_DIV_EN: two's complement operands, quotient truncates
// toward zero, remainder takes the dividend sign. Undefined: unsigned only.
// Ports:
//   clk, rst_n            clock (rising), asynchronous active-low reset
//   start                 request, sampled in IDLE only
//   OperX [OPER1_LENGTH]  dividend, captured on acceptance
//   OperY [OPER2_LENGTH]  divisor, captured on acceptance
//   Quotient, Remainder   results, held until the next done
//   busy                  high from the cycle after acceptance through done
//   done                  one-cycle completion pulse
//   div_by_zero           set with done when the captured divisor was zero
// Latency: done OPER1_LENGTH+1 cycles after acceptance, 1 cycle on divide by 0.
// -----------------------------------------------------------------------------
module seq_divider
   import divider_pkg::*;
#(
   parameter int unsigned OPER1_LENGTH = 8,
   parameter int unsigned OPER2_LENGTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [OPER1_LENGTH-1:0] OperX,
   input  logic [OPER2_LENGTH-1:0] OperY,
   output logic [OPER1_LENGTH-1:0] Quotient,
   output logic [OPER2_LENGTH-1:0] Remainder,
   output logic                    busy,
   output logic                    done,
   output logic                    div_by_zero
);

   localparam int unsigned CntW = cnt_width(OPER1_LENGTH);

   div_state_e              r_state;
   logic [OPER1_LENGTH-1:0] r_dq;       // dividend shifts out at the top, quotient in at the bottom
   logic [OPER2_LENGTH-1:0] r_divisor;
   logic [OPER2_LENGTH:0]   r_prem;
   logic [CntW-1:0]         r_cnt;
   logic [OPER1_LENGTH-1:0] r_quotient;
   logic [OPER2_LENGTH-1:0] r_remainder;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_dbz;

   logic [OPER1_LENGTH-1:0] w_x_mag;
   logic [OPER2_LENGTH-1:0] w_y_mag;
   logic [OPER2_LENGTH:0]   w_next_prem;
   logic                    w_qbit;
   logic [OPER1_LENGTH-1:0] w_q_raw;
   logic [OPER2_LENGTH-1:0] w_r_raw;
   logic [OPER1_LENGTH-1:0] w_q_fin;
   logic [OPER2_LENGTH-1:0] w_r_fin;

   div_step #(
      .OPER2_LENGTH (OPER2_LENGTH)
   ) u_div_step (
      .i_prem    (r_prem),
      .i_msb     (r_dq[OPER1_LENGTH-1]),
      .i_divisor (r_divisor),
      .o_prem    (w_next_prem),
      .o_qbit    (w_qbit)
   );

   // Result of the final iteration, written straight into the output registers.
   assign w_q_raw = {r_dq[OPER1_LENGTH-2:0], w_qbit};
   assign w_r_raw = w_next_prem[OPER2_LENGTH-1:0];

`ifdef SIGNED_DIV_EN
   logic r_neg_q;
   logic r_neg_r;

   // Most-negative dividend maps to itself, which is its correct unsigned magnitude.
   assign w_x_mag = OperX[OPER1_LENGTH-1] ? -OperX : OperX;
   assign w_y_mag = OperY[OPER2_LENGTH-1] ? -OperY : OperY;
   assign w_q_fin = r_neg_q ? -w_q_raw : w_q_raw;
   assign w_r_fin = r_neg_r ? -w_r_raw : w_r_raw;
`else
   assign w_x_mag = OperX;
   assign w_y_mag = OperY;
   assign w_q_fin = w_q_raw;
   assign w_r_fin = w_r_raw;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_dq        <= '0;
         r_divisor   <= '0;
         r_prem      <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_dbz       <= 1'b0;
`ifdef SIGNED_DIV_EN
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start) begin
                  r_dq      <= w_x_mag;
                  r_divisor <= w_y_mag;
                  r_prem    <= '0;
                  r_cnt     <= CntW'(OPER1_LENGTH);
                  r_busy    <= 1'b1;
`ifdef SIGNED_DIV_EN
                  r_neg_q   <= OperX[OPER1_LENGTH-1] ^ OperY[OPER2_LENGTH-1];
                  r_neg_r   <= OperX[OPER1_LENGTH-1];
`endif
                  if (OperY == '0) begin
                     // Skip the iterations; raw dividend bits are reported unsigned.
                     r_state     <= DONE;
                     r_done      <= 1'b1;
                     r_quotient  <= {OPER1_LENGTH{DivZeroQuotBit}};
                     r_remainder <= OperX[OPER2_LENGTH-1:0];
                     r_dbz       <= 1'b1;
                  end else begin
                     r_state <= CALC;
                  end
               end
            end
            CALC: begin
               r_prem <= w_next_prem;
               r_dq   <= w_q_raw;
               r_cnt  <= r_cnt - CntW'(1);
               if (r_cnt == CntW'(1)) begin
                  r_state     <= DONE;
                  r_done      <= 1'b1;
                  r_quotient  <= w_q_fin;
                  r_remainder <= w_r_fin;
                  r_dbz       <= 1'b0;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign Quotient    = r_quotient;
   assign Remainder   = r_remainder;
   assign busy        = r_busy;
   assign done        = r_done;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// -----------------------------------------------------------------------------
// tb_seq_divider
// Self-checking bench for seq_divider (8/8 configuration). Follows the
// SIGNED_DIV_EN macro so the reference model matches the build.
// -----------------------------------------------------------------------------
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] OperX;
   logic [7:0] OperY;
   logic [7:0] Quotient;
   logic [7:0] Remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   seq_divider #(
      .OPER1_LENGTH (8),
      .OPER2_LENGTH (8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .OperX       (OperX),
      .OperY       (OperY),
      .Quotient    (Quotient),
      .Remainder   (Remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division on the operand values.
   function automatic void ref_div(input logic [7:0] x, input logic [7:0] y,
                                   output logic [7:0] q, output logic [7:0] r,
                                   output logic dz);
`ifdef SIGNED_DIV_EN
      int sx, sy, sq, sr;
`endif
      if (y == 8'd0) begin
         q  = 8'hFF;
         r  = x;
         dz = 1'b1;
      end else begin
`ifdef SIGNED_DIV_EN
         sx = int'($signed(x));
         sy = int'($signed(y));
         sq = sx / sy;
         sr = sx % sy;
         q  = sq[7:0];
         r  = sr[7:0];
`else
         q  = x / y;
         r  = x % y;
`endif
         dz = 1'b0;
      end
   endfunction

   // Called at a negedge with the DUT idle. Returns at the negedge after done.
   task automatic run_div(input logic [7:0] x, input logic [7:0] y,
                          output logic [7:0] q, output logic [7:0] r, output logic dz,
                          output int lat, output bit busy_ok);
      start = 1'b1;
      OperX = x;
      OperY = y;
      @(posedge clk);
      #1;
      start = 1'b0;
      OperX = 8'($urandom);
      OperY = 8'($urandom);
      lat     = 0;
      busy_ok = 1'b1;
      q  = '0;
      r  = '0;
      dz = 1'b0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         busy_ok &= (busy === 1'b1);
         if (done === 1'b1) break;
      end
      q  = Quotient;
      r  = Remainder;
      dz = div_by_zero;
      @(negedge clk);
      check_val("done_single", 32'(done), 32'd0);
      check_val("busy_clear", 32'(busy), 32'd0);
   endtask

   task automatic check_op(input string tag, input logic [7:0] x, input logic [7:0] y,
                           output logic [7:0] q, output logic [7:0] r, output logic dz);
      logic [7:0] eq, er;
      logic       edz;
      int         lat;
      bit         bok;
      run_div(x, y, q, r, dz, lat, bok);
      ref_div(x, y, eq, er, edz);
      check_val({tag, "_lat"}, 32'(lat), (y == 8'd0) ? 32'd1 : 32'd9);
      check_val({tag, "_busy"}, 32'(bok), 32'd1);
      check_val({tag, "_q"}, 32'(q), 32'(eq));
      check_val({tag, "_r"}, 32'(r), 32'(er));
      check_val({tag, "_dz"}, 32'(dz), 32'(edz));
   endtask

   initial begin
      logic [7:0] q, r, x, y, eq, er;
      logic       dz, edz;
      int         n_done, done_at, lat;
      bit         bok;

      rst_n = 1'b0;
      start = 1'b0;
      OperX = '0;
      OperY = '0;
      #12;
      check_val("rst_q", 32'(Quotient), 32'd0);
      check_val("rst_r", 32'(Remainder), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_done", 32'(done), 32'd0);
      check_val("rst_dz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // 100 / 7: latency and busy window
      run_div(8'd100, 8'd7, q, r, dz, lat, bok);
      check_val("d100_lat", 32'(lat), 32'd9);
      check_val("d100_busy", 32'(bok), 32'd1);
      check_val("d100_q", 32'(q), 32'd14);
      check_val("d100_r", 32'(r), 32'd2);
      check_val("d100_dz", 32'(dz), 32'd0);

      check_op("d5by0", 8'd5, 8'd0, q, r, dz);
      check_val("d5by0_q_c", 32'(q), 32'hFF);
      check_val("d5by0_r_c", 32'(r), 32'd5);
      check_val("d5by0_dz_c", 32'(dz), 32'd1);

      check_op("d3by10", 8'd3, 8'd10, q, r, dz);
      check_val("d3by10_q_c", 32'(q), 32'd0);
      check_val("d3by10_r_c", 32'(r), 32'd3);
      check_op("d255by1", 8'd255, 8'd1, q, r, dz);
      check_val("d255by1_r_c", 32'(r), 32'd0);
`ifndef SIGNED_DIV_EN
      check_val("d255by1_q_c", 32'(q), 32'd255);
`endif
      check_op("d0by9", 8'd0, 8'd9, q, r, dz);
      check_val("d0by9_q_c", 32'(q), 32'd0);
      check_val("d0by9_r_c", 32'(r), 32'd0);

      // Start held during CALC/DONE must be ignored.
      start = 1'b1;
      OperX = 8'd200;
      OperY = 8'd3;
      @(posedge clk);
      #1;
      start   = 1'b0;
      n_done  = 0;
      done_at = 0;
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 4) begin
            start = 1'b1;
            OperX = 8'd50;
            OperY = 8'd5;
         end
         if (k == 9) start = 1'b0;
         if (done === 1'b1) begin
            n_done++;
            done_at = k;
            q = Quotient;
            r = Remainder;
         end
      end
      ref_div(8'd200, 8'd3, eq, er, edz);
      check_val("ign_ndone", 32'(n_done), 32'd1);
      check_val("ign_at", 32'(done_at), 32'd9);
      check_val("ign_q", 32'(q), 32'(eq));
      check_val("ign_r", 32'(r), 32'(er));
`ifndef SIGNED_DIV_EN
      check_val("ign_q_c", 32'(q), 32'd66);
      check_val("ign_r_c", 32'(r), 32'd2);
`endif
      @(negedge clk);  // cycle 10: idle again
      check_op("after_ign", 8'd50, 8'd5, q, r, dz);

      // Asynchronous reset in the middle of a division.
      start = 1'b1;
      OperX = 8'd100;
      OperY = 8'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mid_rst_q", 32'(Quotient), 32'd0);
      check_val("mid_rst_r", 32'(Remainder), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_done", 32'(done), 32'd0);
      check_val("mid_rst_dz", 32'(div_by_zero), 32'd0);
      @(negedge clk);
      rst_n  = 1'b1;
      n_done = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) n_done++;
      end
      check_val("mid_rst_quiet", 32'(n_done), 32'd0);
      check_op("post_rst", 8'd100, 8'd7, q, r, dz);
      check_val("post_rst_q_c", 32'(q), 32'd14);

`ifdef SIGNED_DIV_EN
      check_op("s_m7by2", 8'hF9, 8'd2, q, r, dz);
      check_val("s_m7by2_q_c", 32'(q), 32'hFD);
      check_val("s_m7by2_r_c", 32'(r), 32'hFF);
      check_op("s_7bym2", 8'd7, 8'hFE, q, r, dz);
      check_val("s_7bym2_q_c", 32'(q), 32'hFD);
      check_val("s_7bym2_r_c", 32'(r), 32'h01);
      check_op("s_ovf", 8'h80, 8'hFF, q, r, dz);
      check_val("s_ovf_q_c", 32'(q), 32'h80);
      check_val("s_ovf_r_c", 32'(r), 32'h00);
      check_op("s_m5by0", 8'hFB, 8'h00, q, r, dz);
      check_val("s_m5by0_q_c", 32'(q), 32'hFF);
      check_val("s_m5by0_r_c", 32'(r), 32'hFB);
      check_val("s_m5by0_dz_c", 32'(dz), 32'd1);
`endif

      // Randomized sweep, with occasional zero divisors.
      for (int i = 0; i < 1000; i++) begin
         x = 8'($urandom);
         y = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom);
         check_op("rnd", x, y, q, r, dz);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative radix-2 restoring divider. It is the inverse-operation companion to the combinational multiplier in the arithmetic block.
- Produces one quotient bit per clock and reports completion through a start/busy/done handshake.
- Sits beside the multiplier behind the same operand naming (OperX dividend, OperY divisor), so the top level can select either engine.

Parameters:
- OPER1_LENGTH, 8, dividend and quotient width in bits (>= 2).
- OPER2_LENGTH, 8, divisor and remainder width in bits (>= 2, <= OPER1_LENGTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; sampled only while in IDLE.
- OperX  in  OPER1_LENGTH  dividend; captured when start is accepted.
- OperY  in  OPER2_LENGTH  divisor; captured when start is accepted.
- Quotient  out  OPER1_LENGTH  result quotient.
- Remainder  out  OPER2_LENGTH  result remainder.
- busy  out  1  high from the cycle after acceptance through the done cycle inclusive.
- done  out  1  one-cycle pulse; results valid from this cycle on.
- div_by_zero  out  1  flag updated with done; high when the captured OperY was 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - Quotient=0, Remainder=0, busy=0, done=0, div_by_zero=0.
  - Internal accumulator and counter cleared.
  - Reset mid-operation aborts immediately; no done pulse is issued.
- States: IDLE, CALC, DONE.
- IDLE, start=1 at cycle 0:
  - Register OperX and OperY.
  - Clear the partial remainder (width OPER2_LENGTH+1) and set counter=OPER1_LENGTH.
  - Next state is CALC. If OperY==0, next state is DONE instead.
- CALC, each cycle:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement the counter. After OPER1_LENGTH iterations go to DONE.
  - Cycles 1..OPER1_LENGTH.
- DONE:
  - Drive done=1 and update Quotient, Remainder and div_by_zero.
  - Next state is IDLE.
  - Normal latency: done at cycle OPER1_LENGTH+1 after acceptance.
- Divide by zero:
  - done at cycle 1.
  - Quotient = all ones, Remainder = OperX[OPER2_LENGTH-1:0], div_by_zero=1.
- Outputs hold their last values until the next DONE. They are not cleared on a new start.
- start while busy=1 (CALC or DONE) is ignored; there is no queueing. A new start is accepted in the cycle after done.
- OperX and OperY may change freely after acceptance without affecting the result.
- Unsigned arithmetic: Quotient*OperY + Remainder == OperX, with Remainder < OperY.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined:
  - Operands are two's complement.
  - Magnitudes are taken at acceptance and the unsigned core is run unchanged.
  - In DONE, the quotient is negated if the operand signs differ, so it truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Overflow case, most-negative dividend divided by -1: Quotient = most-negative value, Remainder = 0, no extra flag.
  - Divide by zero behaves exactly as in unsigned mode.
  - Latency is unchanged.
- Undefined: pure unsigned operation, and no sign logic is synthesized.

Decomposition:
- Package divider_pkg contains:
  - State enum (IDLE, CALC, DONE).
  - Counter width, computed as clog2(OPER1_LENGTH+1).
  - Constants for the divide-by-zero quotient pattern.
- One natural sub-module, div_step: a combinational single restoring iteration.
  - Inputs: partial remainder, dividend MSB, divisor.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once in CALC.

Test Plan:
- Default params, OperX=100, OperY=7, start at cycle 0 -> done pulse at cycle 9, Quotient=14, Remainder=2, div_by_zero=0, busy high cycles 1..9.
- OperX=5, OperY=0 -> done at cycle 1, Quotient=8'hFF, Remainder=5, div_by_zero=1.
- Boundaries:
  - OperX=3, OperY=10 -> Q=0, R=3.
  - OperX=255, OperY=1 -> Q=255, R=0.
  - OperX=0, OperY=9 -> Q=0, R=0.
  - Randomized sweep of 1000 pairs checked against the reference model.
- start pulsed again at cycle 4 with different operands during a 200/3 operation -> ignored. Single done at cycle 9 with Q=66, R=2. A start at cycle 10 is accepted.
- rst_n low at cycle 5 of a running division -> all outputs 0 asynchronously, no done. A fresh start after release completes normally.
- With SIGNED_DIV_EN:
  - -7/2 -> Q=-3, R=-1.
  - 7/-2 -> Q=-3, R=1.
  - -128/-1 -> Q=-128, R=0.
  - -5/0 -> div_by_zero=1, Q=8'hFF, R=8'hFB.
